fc_ram_flatten_writer: RTL and testbench
========================================

Name: fc_ram_flatten_writer

Overview:
- Flatten stage directly upstream of the dense FC activation RAM.
- Accepts LANES-wide int8 activation words from the final conv/pool stage over a valid/ready handshake.
- Serialises each word into one RAM byte write per cycle at consecutive addresses starting from base_addr.
- Signals completion once exactly num_bytes bytes have been written, so the dense layer can start reading.

Parameters:
- DEPTH, 256, FC RAM depth in entries; must match the RAM instance.
- WIDTH, 8, bits per RAM entry / activation.
- LANES, 4, activations per input word; power of two, ≥2.
- ADDR_W, $clog2(DEPTH), RAM address width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; launches a transfer; ignored unless IDLE
- base_addr  in  ADDR_W  first RAM address; sampled on start
- num_bytes  in  ADDR_W+1  bytes to write (0..DEPTH); sampled on start
- in_valid  in  1  upstream word valid
- in_ready  out  1  this block accepts word this cycle
- in_data  in  LANES*WIDTH  lane 0 = bits [WIDTH-1:0], written first
- ram_write_enable  out  1  to RAM write_enable
- ram_write_addr  out  ADDR_W  to RAM write_addr
- ram_data_in  out  WIDTH  to RAM data_in
- busy  out  1  high from cycle after accepted start until done cycle (exclusive)
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse: start rejected on range violation

Behaviour:
- Reset: state IDLE; in_ready, ram_write_enable, busy, done, error = 0; ram_write_addr, ram_data_in = 0; holding register, lane index and counters cleared. Reset mid-transfer aborts immediately; no further writes.
- Registers: addr counter, bytes_left (ADDR_W+1), words_left, hold_data, hold_valid, lane_idx (clog2(LANES)).
- States: IDLE, ACCEPT, FINISH.
- IDLE + start:
  - If base_addr+num_bytes > DEPTH (compute in ADDR_W+2 bits): error=1 next cycle, stay IDLE, no writes.
  - Else if num_bytes==0: done=1 next cycle, stay IDLE.
  - Else: latch addr=base_addr, bytes_left=num_bytes, words_left=ceil(num_bytes/LANES); go ACCEPT; busy=1.
- in_ready (combinational) = ACCEPT && words_left!=0 && (!hold_valid || lane_idx==LANES-1 || bytes_left==1).
- Handshake: transfer when in_valid && in_ready at a rising edge. That edge loads hold_data, sets hold_valid, clears lane_idx and decrements words_left. in_data ignored when no transfer. in_valid may drop or change freely while in_ready=0.
- Write outputs (registered/state-derived):
  - ram_write_enable = hold_valid.
  - ram_data_in = lane lane_idx of hold_data.
  - ram_write_addr = addr.
- Each cycle with hold_valid=1: addr+1, bytes_left-1, lane_idx+1. hold_valid clears after lane LANES-1 or when bytes_left reaches 0, unless a new word is accepted on that same edge.
- Latency: word accepted at edge k → first byte written in cycle k+1. Sustained throughput is 1 byte/cycle with no bubbles between words.
- Partial final word: lanes beyond the remaining bytes are discarded, never written.
- Completion: edge that writes the last byte → state FINISH. FINISH cycle: done=1, busy=0, then IDLE. A start during FINISH is ignored.
- Addresses never wrap; the range check guarantees this. ram_write_enable is never high outside ACCEPT.
- start while busy: ignored, no error.

Test Plan:
- base_addr=0, num_bytes=8, in_valid held high with words 0x04030201, 0x08070605 → writes addr0..7 = 01..08 on 8 consecutive cycles; in_ready drops after 2nd accept; done pulses cycle after addr7 write.
- base_addr=10, num_bytes=6, words 0xDDCCBBAA, 0x44332211 → addr10..15 = AA,BB,CC,DD,11,22; bytes 33,44 never written; exactly 6 write cycles.
- Upstream stalls: in_valid toggles 1,0,0,1 → writes pause with no duplicate or skipped address; final RAM content matches 1-byte/word order.
- base_addr=250, num_bytes=8 → error=1 one cycle, no ram_write_enable, busy stays 0; num_bytes=0 → done only.
- Reset asserted after 3 of 8 bytes written → all outputs 0 next cycle; a new start of 4 bytes afterwards completes correctly from its own base.
- start pulsed again mid-transfer with different base_addr → ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/fc_ram_flatten_writer.sv
// Flatten stage feeding the dense FC activation RAM: unpacks LANES-wide int8 words
// into one byte write per cycle at consecutive addresses, then pulses done.
module fc_ram_flatten_writer #(
   parameter int DEPTH  = 256,
   parameter int WIDTH  = 8,
   parameter int LANES  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [ADDR_W:0]          num_bytes,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_data,
   output logic                     ram_write_enable,
   output logic [ADDR_W-1:0]        ram_write_addr,
   output logic [WIDTH-1:0]         ram_data_in,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   localparam int LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
      $error("LANES must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t                    state_q;
   state_t                    state_d;

   logic [ADDR_W-1:0]         addr;
   logic [ADDR_W:0]           bytes_left;
   logic [ADDR_W:0]           words_left;
   logic [LANES*WIDTH-1:0]    hold_data;
   logic                      hold_valid;
   logic [LANE_W-1:0]         lane_idx;
   logic                      err_pulse;
   logic                      zero_done;

   logic [ADDR_W+1:0]         end_addr;
   logic                      range_bad;
   logic                      launch;
   logic                      accept_go;
   logic                      last_lane;
   logic                      last_byte;
   logic                      xfer;

   function automatic logic [ADDR_W:0] ceil_words(input logic [ADDR_W:0] n);
      logic [ADDR_W+1:0] padded;
      padded = {1'b0, n} + (ADDR_W+2)'(LANES - 1);
      return (ADDR_W+1)'(padded >> LANE_W);
   endfunction

   // Range check is done one bit wider than num_bytes so base+count cannot overflow.
   assign end_addr  = {2'b00, base_addr} + {1'b0, num_bytes};
   assign range_bad = end_addr > (ADDR_W+2)'(DEPTH);
   assign launch    = (state_q == S_IDLE) && start;
   assign accept_go = launch && !range_bad && (num_bytes != '0);
   assign last_lane = (lane_idx == LAST_LANE);
   assign last_byte = (bytes_left == (ADDR_W+1)'(1));
   assign xfer      = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_go) begin
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (hold_valid && last_byte) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A new word may be loaded on the same edge the last byte of the current one
   // drains, which is what keeps the byte stream free of bubbles.
   always_comb begin
      in_ready         = (state_q == S_ACCEPT) && (words_left != '0) &&
                         (!hold_valid || last_lane || last_byte);
      busy             = (state_q == S_ACCEPT);
      done             = (state_q == S_FINISH) || zero_done;
      error            = err_pulse;
      ram_write_enable = hold_valid;
      ram_write_addr   = addr;
      ram_data_in      = hold_data[lane_idx*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr       <= '0;
         bytes_left <= '0;
         words_left <= '0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         lane_idx   <= '0;
         err_pulse  <= 1'b0;
         zero_done  <= 1'b0;
      end else begin
         err_pulse <= launch && range_bad;
         zero_done <= launch && !range_bad && (num_bytes == '0);
         if (accept_go) begin
            addr       <= base_addr;
            bytes_left <= num_bytes;
            words_left <= ceil_words(num_bytes);
            hold_valid <= 1'b0;
            lane_idx   <= '0;
         end else if (state_q == S_ACCEPT) begin
            if (hold_valid) begin
               addr       <= addr + ADDR_W'(1);
               bytes_left <= bytes_left - (ADDR_W+1)'(1);
               lane_idx   <= lane_idx + LANE_W'(1);
               if (last_lane || last_byte) begin
                  hold_valid <= 1'b0;
               end
            end
            if (xfer) begin
               hold_data  <= in_data;
               hold_valid <= 1'b1;
               lane_idx   <= '0;
               words_left <= words_left - (ADDR_W+1)'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fc_ram_flatten_writer.sv
// Scoreboard bench for fc_ram_flatten_writer: expected byte writes are derived from
// the word stream and popped by a monitor whenever the RAM write strobe is seen.
module tb_fc_ram_flatten_writer;
   localparam int DEPTH  = 256;
   localparam int WIDTH  = 8;
   localparam int LANES  = 4;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DW     = LANES * WIDTH;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   num_bytes;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic              ram_write_enable;
   logic [ADDR_W-1:0] ram_write_addr;
   logic [WIDTH-1:0]  ram_data_in;
   logic              busy;
   logic              done;
   logic              error;

   fc_ram_flatten_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_bytes(num_bytes), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .ram_write_enable(ram_write_enable),
      .ram_write_addr(ram_write_addr), .ram_data_in(ram_data_in),
      .busy(busy), .done(done), .error(error)
   );

   typedef struct { int addr; int data; } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  wr_total = 0;
   int  done_count = 0;
   int  err_count = 0;
   int  run_len = 0;
   int  last_wr_cyc = -1;
   int  done_cyc = -1;
   bit  prev_we = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endfunction

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (ram_write_enable) begin
            chk("busy_during_write", busy, 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected no write",
                        ram_write_addr, ram_data_in);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", ram_write_addr, e.addr);
               chk("wr_data", ram_data_in, e.data);
            end
            wr_total++;
            run_len = prev_we ? run_len + 1 : 1;
            last_wr_cyc = cyc;
         end
         prev_we = ram_write_enable;
         if (done) begin
            done_count++;
            done_cyc = cyc;
            chk("busy_low_at_done", busy, 0);
         end
         if (error) err_count++;
      end
   endtask

   // mode: 0 = in_valid always high, 1 = repeating 1,0,0,1, 2 = random
   task automatic run_transfer(input int base, input int n, input int mode, input bit mid_start,
                               input bit fixed, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
      logic [DW-1:0] words[$];
      logic [DW-1:0] w;
      wr_t e;
      int nw, wi, t, d0, e0, wr0;
      bit v;
      nw = (n + LANES - 1) / LANES;
      for (int i = 0; i < nw; i++) begin
         if (fixed) w = (i == 0) ? w0 : w1;
         else w = $urandom;
         words.push_back(w);
      end
      for (int i = 0; i < n; i++) begin
         w = words[i / LANES];
         e.addr = base + i;
         e.data = int'((w >> (WIDTH * (i % LANES))) & 32'hFF);
         exp_q.push_back(e);
      end
      d0 = done_count; e0 = err_count; wr0 = wr_total;
      start = 1; base_addr = ADDR_W'(base); num_bytes = (ADDR_W+1)'(n); in_valid = 0;
      @(negedge clk);
      start = 0; base_addr = ADDR_W'($urandom); num_bytes = (ADDR_W+1)'($urandom);
      #1;
      chk("busy_after_start", busy, 1);
      wi = 0; t = 0;
      while (wi < nw && t < 2000) begin
         case (mode)
            0: v = 1;
            1: v = (t % 4 == 0) || (t % 4 == 3);
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? words[wi] : DW'($urandom);
         if (mid_start && t == 3) begin
            start = 1; base_addr = ADDR_W'(base + 40); num_bytes = 5;
         end else begin
            start = 0;
         end
         #1;
         if (v && in_ready) wi++;
         @(negedge clk);
         t++;
      end
      in_valid = 0; start = 0;
      if (t >= 2000) chk("feed_timeout_words", wi, nw);
      #1;
      chk("in_ready_low_after_last_word", in_ready, 0);
      t = 0;
      while (done_count == d0 && t < 600) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("done_pulses", done_count - d0, 1);
      chk("no_error_pulse", err_count - e0, 0);
      chk("write_count", wr_total - wr0, n);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("done_after_last_write", done_cyc - last_wr_cyc, 1);
      if (mode == 0) chk("writes_back_to_back", run_len, n);
      @(negedge clk);
      #1;
      chk("done_single_cycle", done, 0);
      chk("idle_after_done", busy, 0);
   endtask

   initial begin
      int d0, e0, wr0, t, b, n;
      reset = 1; start = 0; base_addr = 0; num_bytes = 0; in_valid = 0; in_data = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", ram_write_enable, 0);
      chk("rst_addr", ram_write_addr, 0);
      chk("rst_data", ram_data_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      fork
         monitor();
      join_none
      @(negedge clk);
      reset = 0;
      @(negedge clk);

      run_transfer(0, 8, 0, 0, 1, 32'h04030201, 32'h08070605);
      run_transfer(10, 6, 0, 0, 1, 32'hDDCCBBAA, 32'h44332211);
      run_transfer(30, 7, 1, 0, 0, 0, 0);
      run_transfer(60, 8, 0, 1, 0, 0, 0);
      run_transfer(252, 4, 0, 0, 0, 0, 0);
      run_transfer(255, 1, 2, 0, 0, 0, 0);

      // Out-of-range start: error pulse only.
      e0 = err_count; wr0 = wr_total;
      start = 1; base_addr = 250; num_bytes = 8;
      @(negedge clk);
      start = 0;
      #1;
      chk("range_error_pulse", error, 1);
      chk("range_busy_low", busy, 0);
      chk("range_no_done", done, 0);
      @(negedge clk);
      #1;
      chk("range_error_single", error, 0);
      chk("range_still_idle", busy, 0);
      start = 1; base_addr = 1; num_bytes = 256;
      @(negedge clk);
      start = 0;
      #1;
      chk("range_full_plus1_error", error, 1);
      repeat (3) @(negedge clk);
      chk("range_error_count", err_count - e0, 2);
      chk("range_no_writes", wr_total - wr0, 0);

      // Zero-length start: done only.
      d0 = done_count;
      start = 1; base_addr = 5; num_bytes = 0;
      @(negedge clk);
      start = 0;
      #1;
      chk("zero_done_pulse", done, 1);
      chk("zero_busy_low", busy, 0);
      chk("zero_no_error", error, 0);
      @(negedge clk);
      #1;
      chk("zero_done_single", done, 0);
      chk("zero_done_count", done_count - d0, 1);

      // Reset after 3 of 8 bytes written.
      wr0 = wr_total;
      for (int i = 0; i < 3; i++) exp_q.push_back('{20 + i, 8'h11 * (i + 1)});
      start = 1; base_addr = 20; num_bytes = 8; in_valid = 1; in_data = 32'h44332211;
      @(negedge clk);
      start = 0;
      t = 0;
      while (wr_total - wr0 < 3 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      reset = 1; in_valid = 0;
      @(negedge clk);
      #1;
      chk("abort_writes_before_reset", wr_total - wr0, 3);
      chk("abort_we", ram_write_enable, 0);
      chk("abort_addr", ram_write_addr, 0);
      chk("abort_data", ram_data_in, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_done", done, 0);
      reset = 0;
      @(negedge clk);
      chk("abort_scoreboard", exp_q.size(), 0);
      run_transfer(100, 4, 0, 0, 0, 0, 0);

      for (int k = 0; k < 6; k++) begin
         b = $urandom_range(0, DEPTH - 1);
         n = $urandom_range(1, (DEPTH - b < 40) ? DEPTH - b : 40);
         run_transfer(b, n, 2, 0, 0, 0, 0);
      end
      run_transfer(0, 256, 0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
